// File: rtl/ufm_page_prefetch.sv
// ufm_page_prefetch: double-buffered multi-page UFM reader feeding a byte stream consumer.
module ufm_page_prefetch (
   input  logic        clk,
   input  logic        rst,
   input  logic        req,
   input  logic [10:0] page,
   input  logic [7:0]  npages,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [7:0]  out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        ufm_start,
   output logic [10:0] ufm_addr,
   input  logic [7:0]  ufm_data,
   input  logic        ufm_data_stb,
   input  logic        ufm_ready
);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, FILL = 2'd2, DRAIN = 2'd3;
   logic [1:0]  state;
   logic [7:0]  mem [0:31];
   logic [1:0]  full;
   logic        wb, rb;
   logic [3:0]  wi, ri;
   logic [7:0]  rem;
   logic [10:0] addr;
   logic        err_q, done_q, wr, rd;
   assign wr        = state == FILL && ufm_data_stb;
   assign rd        = full[rb] && out_ready;
   assign busy      = state != IDLE;
   assign done      = done_q;
   assign err       = err_q;
   assign out_valid = full[rb];
   // gated so the stale bank contents never show while empty
   assign out_data  = full[rb] ? mem[{rb, ri}] : 8'h00;
   assign ufm_start = state == ISSUE && ufm_ready && !full[wb];
   assign ufm_addr  = addr;
   always_ff @(posedge clk)
      if (wr) mem[{wb, wi}] <= ufm_data;
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         full   <= 2'b00;
         wb     <= 1'b0;
         rb     <= 1'b0;
         wi     <= 4'd0;
         ri     <= 4'd0;
         rem    <= 8'd0;
         addr   <= 11'd0;
         err_q  <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (ufm_data_stb && state != FILL) err_q <= 1'b1;
         if (rd) begin
            ri <= ri + 4'd1;
            if (ri == 4'hf) begin
               full[rb] <= 1'b0;
               rb       <= ~rb;
            end
         end
         case (state)
            IDLE:
               if (req && npages != 8'd0) begin
                  addr  <= page;
                  rem   <= npages;
                  wi    <= 4'd0;
                  ri    <= 4'd0;
                  wb    <= 1'b0;
                  rb    <= 1'b0;
                  full  <= 2'b00;
                  state <= ISSUE;
               end
            ISSUE:
               if (ufm_start) state <= FILL;
            FILL:
               if (ufm_data_stb) begin
                  wi <= wi + 4'd1;
                  if (wi == 4'hf) begin
                     full[wb] <= 1'b1;
                     wb       <= ~wb;
                     addr     <= addr + 11'd1;
                     rem      <= rem - 8'd1;
                     state    <= rem == 8'd1 ? DRAIN : ISSUE;
                  end
               end
            default:
               if (full == 2'b00) begin
                  done_q <= 1'b1;
                  state  <= IDLE;
               end
         endcase
      end
   end
endmodule
